// File: rtl/bpd_pkg.sv
// Shared branch-predictor types and widths for the branch order buffer.
// BOB_CHOICE_UPD_EN adds the per-entry choice-update bits to bob_entry_t.
package bpd_pkg;
  localparam int PC_W    = 64;
  localparam int GHIST_W = 12;
  localparam int LHIST_W = 10;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [GHIST_W-1:0] bhr;
    logic [LHIST_W-1:0] lochist;
    logic               pred;
`ifdef BOB_CHOICE_UPD_EN
    logic               ch_we;
    logic               ch_ud;
`endif
  } bob_entry_t;
endpackage

// File: rtl/bob_ram.sv
// DEPTH x bob_entry_t register array: synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge; no reset.
import bpd_pkg::*;

module bob_ram #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  bob_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output bob_entry_t               rdata
);
  bob_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/branch_order_buf.sv
// In-order buffer of in-flight conditional branches; retirement emits a registered update bundle.
// One alloc + one retire per cycle; alloc while full is dropped. Macro: BOB_CHOICE_UPD_EN.
import bpd_pkg::*;

module branch_order_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       alloc_i,
  input  logic [PC_W-1:0]            alloc_pc_i,
  input  logic [GHIST_W-1:0]         alloc_bhr_i,
  input  logic [LHIST_W-1:0]         alloc_lochist_i,
  input  logic                       alloc_pred_i,
  input  logic                       alloc_ch_we_i,
  input  logic                       alloc_ch_ud_i,
  input  logic                       rt_valid_i,
  input  logic                       rt_brdir_i,
  input  logic                       ext_flush_i,
  output logic                       bob_full_o,
  output logic                       bob_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] bob_count_o,
  output logic                       bob_valid_r_o,
  output logic [PC_W-1:0]            bob_pc_r_o,
  output logic [GHIST_W-1:0]         bob_bhr_r_o,
  output logic [LHIST_W-1:0]         bob_lochist_r_o,
  output logic                       bob_brdir_r_o,
  output logic                       bob_mispred_r_o,
  output logic                       bob_flush_r_o,
  output logic                       bob_ch_we_r_o,
  output logic                       bob_ch_ud_r_o,
  output logic                       bob_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head, tail, head_nxt, tail_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          full_r, empty_r;
  logic          do_retire, do_alloc, mispred;
  bob_entry_t    wr_ent, rd_ent;

  always_comb begin
    wr_ent         = '0;
    wr_ent.pc      = alloc_pc_i;
    wr_ent.bhr     = alloc_bhr_i;
    wr_ent.lochist = alloc_lochist_i;
    wr_ent.pred    = alloc_pred_i;
`ifdef BOB_CHOICE_UPD_EN
    wr_ent.ch_we   = alloc_ch_we_i;
    wr_ent.ch_ud   = alloc_ch_ud_i;
`endif
  end

  bob_ram #(.DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (do_alloc),
    .waddr (tail),
    .wdata (wr_ent),
    .raddr (head),
    .rdata (rd_ent)
  );

  // Full/empty are the registered view of count, so fetch sees no input-to-output path.
  assign do_retire = rt_valid_i & ~empty_r & ~ext_flush_i;
  assign mispred   = do_retire & (rd_ent.pred ^ rt_brdir_i);
  assign do_alloc  = alloc_i & ~full_r & ~ext_flush_i & ~mispred;

  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    if (ext_flush_i) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end else if (mispred) begin
      head_nxt  = head + PW'(1);
      tail_nxt  = head + PW'(1);
      count_nxt = '0;
    end else begin
      if (do_retire) head_nxt = head + PW'(1);
      if (do_alloc)  tail_nxt = tail + PW'(1);
      if (do_alloc & ~do_retire)      count_nxt = count + CW'(1);
      else if (~do_alloc & do_retire) count_nxt = count - CW'(1);
    end
  end

  logic ch_we_r, ch_ud_r;

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      full_r          <= 1'b0;
      empty_r         <= 1'b1;
      bob_valid_r_o   <= 1'b0;
      bob_pc_r_o      <= '0;
      bob_bhr_r_o     <= '0;
      bob_lochist_r_o <= '0;
      bob_brdir_r_o   <= 1'b0;
      bob_mispred_r_o <= 1'b0;
      ch_we_r         <= 1'b0;
      ch_ud_r         <= 1'b0;
      bob_err_o       <= 1'b0;
    end else begin
      head          <= head_nxt;
      tail          <= tail_nxt;
      count         <= count_nxt;
      full_r        <= (count_nxt == CW'(DEPTH));
      empty_r       <= (count_nxt == '0);
      bob_valid_r_o <= do_retire;
      bob_err_o     <= bob_err_o | (rt_valid_i & empty_r);
      if (do_retire) begin
        bob_pc_r_o      <= rd_ent.pc;
        bob_bhr_r_o     <= rd_ent.bhr;
        bob_lochist_r_o <= rd_ent.lochist;
        bob_brdir_r_o   <= rt_brdir_i;
        bob_mispred_r_o <= rd_ent.pred ^ rt_brdir_i;
`ifdef BOB_CHOICE_UPD_EN
        ch_we_r         <= rd_ent.ch_we;
        ch_ud_r         <= rd_ent.ch_ud;
`endif
      end
    end
  end

  assign bob_full_o    = full_r;
  assign bob_empty_o   = empty_r;
  assign bob_count_o   = count;
  assign bob_flush_r_o = bob_mispred_r_o & bob_valid_r_o;

`ifdef BOB_CHOICE_UPD_EN
  assign bob_ch_we_r_o = ch_we_r & bob_valid_r_o;
  assign bob_ch_ud_r_o = ch_ud_r & bob_valid_r_o;
`else
  // Choice table is trained elsewhere in this build; the holding regs stay at reset.
  assign bob_ch_we_r_o = 1'b0;
  assign bob_ch_ud_r_o = 1'b0 & ch_we_r & ch_ud_r;
`endif
endmodule

// File: doc/branch_order_buf.md
# branch_order_buf

In-order buffer of in-flight conditional branches between the fetch-stage direction predictor and branch resolution. One entry per predicted conditional branch holds the prediction-time PC, global history, local history, predicted direction and choice-update hints. Entries retire in program order when execute resolves them. Each retirement produces the registered update bundle (`bob_*_r`) that trains the gshare, local and choice tables and repairs global history on a mispredict flush.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥2.
- `GHIST_W`, 12: global history width.
- `LHIST_W`, 10: local history width.
- `clock`  in  1: clock.
- `reset_n`  in  1: reset; asynchronous, active-high.
- `alloc_i`  in  1: allocate one entry. Asserted with a predicted conditional branch in F1.
- `alloc_pc_i`  in  64: branch PC.
- `alloc_bhr_i`  in  GHIST_W: global history used for the prediction.
- `alloc_lochist_i`  in  LHIST_W: local history used for the prediction.
- `alloc_pred_i`  in  1: final predicted direction.
- `alloc_ch_we_i`, `alloc_ch_ud_i`  in  1 each: choice-table update enable and direction.
- `rt_valid_i`  in  1: the oldest branch resolved this cycle.
- `rt_brdir_i`  in  1: actual direction.
- `ext_flush_i`  in  1: exception/trap flush; discards all entries.
- `bob_full_o`  out  1: no free entry; fetch must stall conditional branches.
- `bob_empty_o`  out  1: no entries.
- `bob_count_o`  out  $clog2(DEPTH+1): occupancy.
- `bob_valid_r_o`  out  1: update bundle valid (one-cycle pulse per retirement).
- `bob_pc_r_o`  out  64: PC of the retired entry.
- `bob_bhr_r_o`  out  GHIST_W: global history of the retired entry.
- `bob_lochist_r_o`  out  LHIST_W: local history of the retired entry.
- `bob_brdir_r_o`  out  1: actual direction.
- `bob_mispred_r_o`  out  1: predicted ≠ actual.
- `bob_flush_r_o`  out  1: equals `bob_mispred_r_o & bob_valid_r_o`; drives the predictor flush and BHR repair.
- `bob_ch_we_r_o`, `bob_ch_ud_r_o`  out  1 each: choice update for the retired entry.
- `bob_err_o`  out  1: sticky; set by a resolve while empty.

## Operation
- Circular buffer with `head` (oldest), `tail` (next free) and `count`. Pointers wrap modulo DEPTH.
- Allocate:
  - When `alloc_i & !bob_full_o & !ext_flush_i` and no mispredict resolves this cycle, write the entry at `tail`, then increment `tail` and `count`.
  - `alloc_i` while full is dropped. The fetch stall is the requester's duty.
- Retire: when `rt_valid_i & !bob_empty_o`:
  - Read the `head` entry.
  - Register the update bundle with `mispred = pred ^ rt_brdir_i`.
  - Increment `head` and decrement `count`.
- Mispredict retire: the entry retires normally. Every younger entry is discarded (`tail ← head+1`, `count ← 0`), and any same-cycle allocation is dropped.
- Simultaneous allocate and correct retire: both take effect and `count` is unchanged. When full, the allocation is still dropped because full is evaluated on the current-cycle `count`.
- `ext_flush_i`: `head`, `tail` and `count` clear to 0. Any same-cycle retire and allocate are ignored, and `bob_valid_r_o` is 0 next cycle.
- Resolve while empty: ignored, and `bob_err_o` is set.
- Reset values:
  - Pointers, `count`, all `bob_*_r_o` and `bob_err_o` are 0.
  - `bob_empty_o` is 1 and `bob_full_o` is 0.
  - Payload storage is not reset.

## Timing
- Retire sampled at edge N gives the bundle valid during cycle N+1 only. The bundle holds its values until the next retirement, and `bob_valid_r_o` returns to 0.
- Flush latency: a mispredict resolve at edge N gives `bob_flush_r_o` = 1 during N+1, and the buffer is empty from N+1.
- A resolve in cycle N+1 after a mispredict finds the buffer empty and sets `bob_err_o`.
- Allocation at edge N makes the entry retireable from cycle N+1.
- `bob_full_o`, `bob_empty_o` and `bob_count_o` come directly from registers: no combinational path from inputs.
- Throughput: one allocate and one retire per cycle.

## Configuration
- `BOB_CHOICE_UPD_EN` defined: per-entry `ch_we`/`ch_ud` bits are stored and driven to `bob_ch_we_r_o`/`bob_ch_ud_r_o`, qualified by `bob_valid_r_o`.
- Undefined: the storage bits are removed, and both outputs are tied to 0. The choice table is then trained elsewhere.

## Structure
- Shared package `bpd_pkg` holds:
  - `GHIST_W`, `LHIST_W` and `PC_W` (64);
  - typedef `bob_entry_t` {pc, bhr, lochist, pred, ch_we, ch_ud}.
- Sub-module `bob_ram`: DEPTH × `bob_entry_t` register array with one synchronous write port and one asynchronous read port at `head`. No reset.
- Pointer/count control and output registers live in the top.

## Test plan
- Reset mid-operation:
  - Stimulus: allocate 3 entries, then assert `reset_n`.
  - Response: `count`=0, `empty`=1, all outputs 0. A resolve afterwards sets `bob_err_o`.
- In-order retire:
  - Stimulus: allocate PCs 0x1000, 0x1004, 0x1008 (pred 1,0,1), then resolve 1,0,1.
  - Response: bundles in order with `mispred`=0, each `valid` for exactly one cycle.
- Full boundary:
  - Stimulus: allocate 16 entries, then `alloc_i` with a simultaneous correct resolve.
  - Response: `full`=1, the allocation is dropped, and `count` goes to 15.
- Wrap-around:
  - Stimulus: run 40 alternating allocate/retire cycles.
  - Response: PCs and histories return uncorrupted across the pointer wrap, and `count` stays at or below 1.
- Mispredict flush:
  - Stimulus: 4 entries with head pred=1 and bhr 0xABC; resolve 0 with a simultaneous allocate.
  - Response: next cycle `flush_r`=1, `bhr_r`=0xABC, `brdir_r`=0, `empty`=1, and the allocation is dropped.
- External flush and macro:
  - Stimulus: `ext_flush_i` together with `rt_valid_i`.
  - Response: no bundle and `count`=0.
  - With `BOB_CHOICE_UPD_EN` undefined, `ch_*` outputs stay 0 when `alloc_ch_we_i`=1.
